utlb_requester: RTL and testbench

- Small fully-associative micro-TLB that sits in front of the shared TLB responder. One instance per side (fetch or load/store).
- Lookups are answered combinationally from local entries.
- On a miss it issues a one-cycle request to the shared TLB, waits for the matching response valid, fills an entry, and releases the stall so the client can replay.
- It is the initiator end of the iside/dside TLB request/response interface.

---
 rtl/utlb_requester_if.sv | 24 ++
 rtl/utlb_requester.sv | 162 ++++++++++++++++
 tb/tb_utlb_requester.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utlb_requester_if.sv
// Request/response channel between a micro-TLB (master) and the shared TLB responder (slave).
interface utlb_requester_if #(
  parameter int unsigned VPN_W = 52,
  parameter int unsigned PPN_W = 52
);
  logic             tlb_req;
  logic [VPN_W-1:0] tlb_vpn;
  logic             tlb_rsp_valid;
  logic [PPN_W-1:0] tlb_rsp_paddr;
  logic             tlb_rsp_r;
  logic             tlb_rsp_w;
  logic             tlb_rsp_x;
  logic             tlb_rsp_bogus;

  modport master (
    output tlb_req, tlb_vpn,
    input  tlb_rsp_valid, tlb_rsp_paddr, tlb_rsp_r, tlb_rsp_w, tlb_rsp_x, tlb_rsp_bogus
  );

  modport slave (
    input  tlb_req, tlb_vpn,
    output tlb_rsp_valid, tlb_rsp_paddr, tlb_rsp_r, tlb_rsp_w, tlb_rsp_x, tlb_rsp_bogus
  );
endinterface

// File: rtl/utlb_requester.sv
// Fully-associative micro-TLB with combinational lookup and a single outstanding miss to the shared TLB.
// Optional UTLB_PERF_CNT_EN adds perf_hits / perf_misses counters.
module utlb_requester #(
  parameter int unsigned N_ENTRIES = 4,
  parameter int unsigned VPN_W     = 52,
  parameter int unsigned PPN_W     = 52,
  parameter bit          IS_ISIDE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [VPN_W-1:0] lookup_vpn,
  input  logic             lookup_store,
  output logic             lookup_hit,
  output logic [PPN_W-1:0] lookup_ppn,
  output logic             lookup_fault,
  output logic             busy,
  input  logic             flush,
  utlb_requester_if.master tlb
`ifdef UTLB_PERF_CNT_EN
  ,
  output logic [31:0]      perf_hits,
  output logic [31:0]      perf_misses
`endif
);

  localparam int unsigned PTR_W = $clog2(N_ENTRIES);

  typedef struct packed {
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             r;
    logic             w;
    logic             x;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  entry_t               entry_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] valid_q;
  logic [PTR_W-1:0]     ptr_q;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             drop_q, drop_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic             fill;

  logic             hit;
  logic [PPN_W-1:0] hit_ppn;
  logic             perm_ok;

  // Parallel tag compare; fills only follow a miss so at most one entry matches.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    perm_ok = 1'b0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[PTR_W'(i)] && (entry_q[PTR_W'(i)].vpn == lookup_vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | entry_q[PTR_W'(i)].ppn;
        perm_ok = perm_ok | (IS_ISIDE ? entry_q[PTR_W'(i)].x
                                      : (lookup_store ? entry_q[PTR_W'(i)].w : entry_q[PTR_W'(i)].r));
      end
    end
  end

  assign lookup_hit   = hit;
  assign lookup_ppn   = hit_ppn;
  assign lookup_fault = (hit & ~perm_ok) | fault_q;
  assign busy         = busy_q;
  assign tlb.tlb_req  = req_q;
  assign tlb.tlb_vpn  = vpn_q;

  // Miss handling: one-cycle request, then wait for the response.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    busy_d  = busy_q;
    fault_d = 1'b0;
    drop_d  = drop_q;
    vpn_d   = vpn_q;
    fill    = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        busy_d = 1'b0;
        if (lookup_valid && !hit && !flush) begin
          state_d = REQ;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          vpn_d   = lookup_vpn;
        end
      end
      REQ: begin
        state_d = WAIT;
        if (flush) drop_d = 1'b1;
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        if (tlb.tlb_rsp_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          drop_d  = 1'b0;
          fault_d = tlb.tlb_rsp_bogus;
          // A flush in this same cycle also wins over the fill.
          fill    = !tlb.tlb_rsp_bogus && !drop_q && !flush;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
      vpn_q   <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      drop_q  <= drop_d;
      vpn_q   <= vpn_d;
      if (flush) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[ptr_q] <= 1'b1;
      end
      if (fill) ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  // Entry payload carries no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      entry_q[ptr_q] <= '{vpn: vpn_q, ppn: tlb.tlb_rsp_paddr,
                          r: tlb.tlb_rsp_r, w: tlb.tlb_rsp_w, x: tlb.tlb_rsp_x};
    end
  end

`ifdef UTLB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (lookup_valid && hit) perf_hits <= perf_hits + 32'd1;
      if ((state_q == IDLE) && (state_d == REQ)) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_utlb_requester.sv
// Self-checking bench for utlb_requester: directed scenarios plus a randomized run against a table model.
module tb_utlb_requester;
  localparam int unsigned N  = 4;
  localparam int unsigned VW = 52;
  localparam int unsigned PW = 52;
  localparam logic [VW-1:0] IDLE_VPN = '1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          lookup_valid, lookup_store, flush;
  logic [VW-1:0] lookup_vpn;
  logic          lookup_hit, lookup_fault, busy;
  logic [PW-1:0] lookup_ppn;

  logic          i_lookup_valid, i_lookup_store, i_flush;
  logic [VW-1:0] i_lookup_vpn;
  logic          i_hit, i_fault, i_busy;
  logic [PW-1:0] i_ppn;

  utlb_requester_if #(.VPN_W(VW), .PPN_W(PW)) d_if ();
  utlb_requester_if #(.VPN_W(VW), .PPN_W(PW)) i_if ();

`ifdef UTLB_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses, i_perf_hits, i_perf_misses;
`endif

  utlb_requester #(.N_ENTRIES(N), .VPN_W(VW), .PPN_W(PW), .IS_ISIDE(1'b0)) dut (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn),
    .lookup_store(lookup_store), .lookup_hit(lookup_hit), .lookup_ppn(lookup_ppn),
    .lookup_fault(lookup_fault), .busy(busy), .flush(flush), .tlb(d_if)
`ifdef UTLB_PERF_CNT_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  utlb_requester #(.N_ENTRIES(N), .VPN_W(VW), .PPN_W(PW), .IS_ISIDE(1'b1)) dut_i (
    .clk(clk), .reset(reset), .lookup_valid(i_lookup_valid), .lookup_vpn(i_lookup_vpn),
    .lookup_store(i_lookup_store), .lookup_hit(i_hit), .lookup_ppn(i_ppn),
    .lookup_fault(i_fault), .busy(i_busy), .flush(i_flush), .tlb(i_if)
`ifdef UTLB_PERF_CNT_EN
    , .perf_hits(i_perf_hits), .perf_misses(i_perf_misses)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: table of translations filled round-robin by fill count.
  logic          m_valid [N];
  logic [VW-1:0] m_vpn   [N];
  logic [PW-1:0] m_ppn   [N];
  logic          m_r [N], m_w [N], m_x [N];
  int unsigned   m_fills, m_hits, m_misses;

  function automatic void m_flush();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void m_reset();
    m_flush();
    m_fills = 0; m_hits = 0; m_misses = 0;
  endfunction

  function automatic void m_fill(input logic [VW-1:0] vpn, input logic [PW-1:0] ppn,
                                 input logic r, input logic w, input logic x);
    int slot;
    slot = int'(m_fills % N);
    m_valid[slot] = 1'b1; m_vpn[slot] = vpn; m_ppn[slot] = ppn;
    m_r[slot] = r; m_w[slot] = w; m_x[slot] = x;
    m_fills++;
  endfunction

  function automatic bit m_find(input logic [VW-1:0] vpn, output int idx);
    idx = -1;
    for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == vpn) idx = i;
    return idx >= 0;
  endfunction

  function automatic bit m_perm_ok(input int idx, input bit store);
    return store ? m_w[idx] : m_r[idx];
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_rsp();
    d_if.tlb_rsp_valid = 1'b0; d_if.tlb_rsp_paddr = '0;
    d_if.tlb_rsp_r = 1'b0; d_if.tlb_rsp_w = 1'b0; d_if.tlb_rsp_x = 1'b0; d_if.tlb_rsp_bogus = 1'b0;
    i_if.tlb_rsp_valid = 1'b0; i_if.tlb_rsp_paddr = '0;
    i_if.tlb_rsp_r = 1'b0; i_if.tlb_rsp_w = 1'b0; i_if.tlb_rsp_x = 1'b0; i_if.tlb_rsp_bogus = 1'b0;
  endtask

  task automatic apply_reset();
    cycle();
    reset = 1'b1;
    lookup_valid = 1'b0; lookup_store = 1'b0; flush = 1'b0; lookup_vpn = IDLE_VPN;
    i_lookup_valid = 1'b0; i_lookup_store = 1'b0; i_flush = 1'b0; i_lookup_vpn = IDLE_VPN;
    idle_rsp();
    cycle();
    cycle();
    reset = 1'b0;
    m_reset();
  endtask

  // One full miss on the d-side: request, wait tat cycles, respond, replay.
  task automatic do_miss(input logic [VW-1:0] vpn, input bit store, input logic [PW-1:0] ppn,
                         input bit r, input bit w, input bit x, input bit bogus,
                         input int tat, input int flush_at);
    int idx; bit exp_hit; logic [PW-1:0] exp_ppn; bit exp_fault; bit flushed;
    cycle();
    lookup_valid = 1'b1; lookup_vpn = vpn; lookup_store = store; flush = 1'b0;
    settle();
    checks++;
    if (lookup_hit !== 1'b0) begin
      errors++; $display("FAIL miss_detect vpn=%h: hit=%b want 0", vpn, lookup_hit);
    end
    cycle();
    settle();
    m_misses++;
    checks++;
    if (d_if.tlb_req !== 1'b1 || d_if.tlb_vpn !== vpn || busy !== 1'b1) begin
      errors++; $display("FAIL req_issue: req=%b vpn=%h busy=%b want 1 %h 1", d_if.tlb_req, d_if.tlb_vpn, busy, vpn);
    end
    flushed = 1'b0;
    for (int c = 1; c <= tat; c++) begin
      cycle();
      flush = (c == flush_at);
      if (c == flush_at) flushed = 1'b1;
      if (c == tat) begin
        d_if.tlb_rsp_valid = 1'b1; d_if.tlb_rsp_paddr = ppn;
        d_if.tlb_rsp_r = r; d_if.tlb_rsp_w = w; d_if.tlb_rsp_x = x; d_if.tlb_rsp_bogus = bogus;
      end
      settle();
      checks++;
      if (d_if.tlb_req !== 1'b0 || busy !== 1'b1 || d_if.tlb_vpn !== vpn) begin
        errors++; $display("FAIL wait_hold c=%0d: req=%b busy=%b vpn=%h want 0 1 %h", c, d_if.tlb_req, busy, d_if.tlb_vpn, vpn);
      end
    end
    cycle();
    idle_rsp();
    d_if.tlb_rsp_paddr = PW'($urandom);
    flush = 1'b0;
    lookup_valid = 1'b0;
    if (flushed) m_flush();
    else if (!bogus) m_fill(vpn, ppn, r, w, x);
    exp_hit   = m_find(vpn, idx);
    exp_ppn   = exp_hit ? m_ppn[idx] : '0;
    exp_fault = bogus || (exp_hit && !m_perm_ok(idx, store));
    settle();
    checks++;
    if (busy !== 1'b0 || d_if.tlb_req !== 1'b0 || lookup_hit !== exp_hit ||
        lookup_ppn !== exp_ppn || lookup_fault !== exp_fault) begin
      errors++;
      $display("FAIL replay vpn=%h: busy=%b req=%b hit=%b ppn=%h fault=%b want 0 0 %b %h %b",
               vpn, busy, d_if.tlb_req, lookup_hit, lookup_ppn, lookup_fault, exp_hit, exp_ppn, exp_fault);
    end
    cycle();
    lookup_vpn = IDLE_VPN;
    settle();
    checks++;
    if (lookup_fault !== 1'b0 || busy !== 1'b0 || d_if.tlb_req !== 1'b0) begin
      errors++; $display("FAIL after_rsp: fault=%b busy=%b req=%b want 0 0 0", lookup_fault, busy, d_if.tlb_req);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    lookup_vpn = VW'(20'h12345);
    settle();
    checks++;
    if (busy !== 1'b0 || d_if.tlb_req !== 1'b0 || d_if.tlb_vpn !== '0 ||
        lookup_fault !== 1'b0 || lookup_hit !== 1'b0 || lookup_ppn !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b req=%b vpn=%h fault=%b hit=%b ppn=%h want all 0",
               busy, d_if.tlb_req, d_if.tlb_vpn, lookup_fault, lookup_hit, lookup_ppn);
    end
  endtask

  task automatic test_cold_miss();
    apply_reset();
    do_miss(VW'(20'h12345), 1'b0, PW'(20'h12345), 1'b1, 1'b1, 1'b0, 1'b0, 2, -1);
    cycle();
    lookup_vpn = VW'(20'h12345);
    settle();
    checks++;
    if (lookup_hit !== 1'b1 || lookup_ppn !== PW'(20'h12345) || lookup_fault !== 1'b0) begin
      errors++; $display("FAIL cold_hit: hit=%b ppn=%h fault=%b want 1 12345 0", lookup_hit, lookup_ppn, lookup_fault);
    end
  endtask

  task automatic test_perm_iside();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      cycle();
      i_lookup_valid = 1'b1; i_lookup_vpn = VW'(20'h700 + k);
      settle();
      cycle();
      settle();
      checks++;
      if (i_if.tlb_req !== 1'b1 || i_if.tlb_vpn !== VW'(20'h700 + k)) begin
        errors++; $display("FAIL iside_req k=%0d: req=%b vpn=%h", k, i_if.tlb_req, i_if.tlb_vpn);
      end
      cycle();
      cycle();
      i_if.tlb_rsp_valid = 1'b1; i_if.tlb_rsp_paddr = PW'(20'hABC0 + k);
      i_if.tlb_rsp_r = 1'b1; i_if.tlb_rsp_w = 1'b1; i_if.tlb_rsp_x = k[0];
      cycle();
      idle_rsp();
      settle();
      checks++;
      if (i_hit !== 1'b1 || i_ppn !== PW'(20'hABC0 + k) || i_fault !== (k == 0)) begin
        errors++; $display("FAIL iside_perm k=%0d: hit=%b ppn=%h fault=%b want 1 %h %b", k, i_hit, i_ppn, i_fault, PW'(20'hABC0 + k), k == 0);
      end
      cycle();
      settle();
      checks++;
      if (i_if.tlb_req !== 1'b0 || i_busy !== 1'b0) begin
        errors++; $display("FAIL iside_no_req k=%0d: req=%b busy=%b want 0 0", k, i_if.tlb_req, i_busy);
      end
      i_lookup_valid = 1'b0;
    end
  endtask

  task automatic test_replacement();
    logic [PW-1:0] ppns [6];
    apply_reset();
    for (int v = 1; v <= 5; v++) begin
      ppns[v] = PW'($urandom);
      do_miss(VW'(v), 1'b0, ppns[v], 1'b1, 1'($urandom), 1'($urandom), 1'b0, 2, -1);
    end
    for (int v = 1; v <= 5; v++) begin
      cycle();
      lookup_vpn = VW'(v);
      settle();
      checks++;
      if (lookup_hit !== (v != 1) || lookup_ppn !== ((v != 1) ? ppns[v] : '0)) begin
        errors++; $display("FAIL replace vpn=%0d: hit=%b ppn=%h want %b", v, lookup_hit, lookup_ppn, v != 1);
      end
    end
    do_miss(VW'(1), 1'b0, PW'(20'h11111), 1'b1, 1'b0, 1'b0, 1'b0, 2, -1);
  endtask

  task automatic test_flush_wait();
    apply_reset();
    do_miss(VW'(20'h55), 1'b0, PW'(20'h5555), 1'b1, 1'b1, 1'b1, 1'b0, 3, 1);
    do_miss(VW'(20'h55), 1'b0, PW'(20'h5555), 1'b1, 1'b1, 1'b1, 1'b0, 2, -1);
    cycle();
    lookup_valid = 1'b1; lookup_vpn = VW'(20'h99); flush = 1'b1;
    cycle();
    lookup_valid = 1'b0; flush = 1'b0; lookup_vpn = VW'(20'h55);
    m_flush();
    settle();
    checks++;
    if (d_if.tlb_req !== 1'b0 || busy !== 1'b0 || lookup_hit !== 1'b0) begin
      errors++; $display("FAIL idle_flush: req=%b busy=%b hit=%b want 0 0 0", d_if.tlb_req, busy, lookup_hit);
    end
  endtask

  task automatic test_bogus();
    apply_reset();
    do_miss(VW'(20'h2468), 1'b1, PW'(20'h1357), 1'b1, 1'b1, 1'b1, 1'b1, 2, -1);
`ifdef UTLB_PERF_CNT_EN
    checks++;
    if (perf_misses !== 32'd1 || perf_hits !== 32'd0) begin
      errors++; $display("FAIL bogus_perf: misses=%0d hits=%0d want 1 0", perf_misses, perf_hits);
    end
`endif
  endtask

  task automatic test_reset_mid_miss();
    apply_reset();
    cycle();
    lookup_valid = 1'b1; lookup_vpn = VW'(20'h3333); lookup_store = 1'b0;
    cycle();
    cycle();
    reset = 1'b1; lookup_valid = 1'b0;
    cycle();
    reset = 1'b0;
    m_reset();
    d_if.tlb_rsp_valid = 1'b1; d_if.tlb_rsp_paddr = PW'(20'h4444);
    d_if.tlb_rsp_r = 1'b1; d_if.tlb_rsp_w = 1'b1;
    settle();
    checks++;
    if (busy !== 1'b0 || d_if.tlb_req !== 1'b0 || d_if.tlb_vpn !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b req=%b vpn=%h want 0 0 0", busy, d_if.tlb_req, d_if.tlb_vpn);
    end
    cycle();
    idle_rsp();
    lookup_vpn = VW'(20'h3333);
    settle();
    checks++;
    if (lookup_hit !== 1'b0) begin
      errors++; $display("FAIL stale_rsp_fill: hit=%b want 0", lookup_hit);
    end
    do_miss(VW'(20'h3333), 1'b0, PW'(20'h4444), 1'b1, 1'b1, 1'b0, 1'b0, 2, -1);
  endtask

  task automatic test_random();
    int idx; logic [VW-1:0] vpn; bit store; int tat;
    for (int it = 0; it < 60; it++) begin
      vpn = VW'($urandom_range(1, 8));
      store = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        m_flush();
      end
      if (m_find(vpn, idx)) begin
        cycle();
        lookup_valid = 1'b1; lookup_vpn = vpn; lookup_store = store;
        m_hits++;
        settle();
        checks++;
        if (lookup_hit !== 1'b1 || lookup_ppn !== m_ppn[idx] || lookup_fault !== !m_perm_ok(idx, store)) begin
          errors++;
          $display("FAIL rand_hit vpn=%h st=%b: hit=%b ppn=%h fault=%b want 1 %h %b",
                   vpn, store, lookup_hit, lookup_ppn, lookup_fault, m_ppn[idx], !m_perm_ok(idx, store));
        end
        cycle();
        lookup_valid = 1'b0;
      end else begin
        tat = $urandom_range(1, 4);
        do_miss(vpn, store, PW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), tat,
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, tat)) : -1);
      end
    end
`ifdef UTLB_PERF_CNT_EN
    settle();
    checks++;
    if (perf_hits !== m_hits || perf_misses !== m_misses) begin
      errors++; $display("FAIL rand_perf: hits=%0d misses=%0d want %0d %0d", perf_hits, perf_misses, m_hits, m_misses);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    lookup_valid = 1'b0; lookup_store = 1'b0; flush = 1'b0; lookup_vpn = IDLE_VPN;
    i_lookup_valid = 1'b0; i_lookup_store = 1'b0; i_flush = 1'b0; i_lookup_vpn = IDLE_VPN;
    idle_rsp();
    test_reset();
    test_cold_miss();
    test_perm_iside();
    test_replacement();
    test_flush_wait();
    test_bogus();
    test_reset_mid_miss();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
